// File: rtl/sobel_mag_sq_seq.sv
// Sequential gradient-energy generator. It computes
// R = sat16((gx^2 + gy^2) >> SCALE_SHIFT) with two parallel bit-serial
// shift-add squarers, then feeds the 16-bit radicand to the sqrt unit.
module sobel_mag_sq_seq #(
  parameter int W           = 11,
  parameter int SCALE_SHIFT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] gx,
  input  logic signed [W-1:0] gy,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [15:0]         r_out,
  output logic                sat,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = 2 * W;
  // Sum width is never narrower than 17 bits, so the saturation test is always well formed.
  localparam int SW = (2 * W + 1 > 17) ? 2 * W + 1 : 17;

  typedef enum logic [1:0] {IDLE, MUL, SAT, OUT} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  ax, ay;
  logic [AW-1:0] acc_x, acc_y;
  logic [AW-1:0] px, py;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum, s;
  logic          last_iter;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign last_iter = (cnt == CW'(W - 1));

  // Next-state decode. MUL always runs W cycles, with no early exit on small operands.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)  state_nx = MUL;
      MUL:  if (last_iter) state_nx = SAT;
      SAT:                 state_nx = OUT;
      OUT:  if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register. rst also masks in_ready.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT);

  // Partial products for iteration cnt, plus the scaled sum of squares
  always_comb begin
    px  = ax[cnt] ? (AW'(ax) << cnt) : '0;
    py  = ay[cnt] ? (AW'(ay) << cnt) : '0;
    sum = SW'(acc_x) + SW'(acc_y);
    s   = sum >> SCALE_SHIFT;
  end

  // Datapath: capture magnitudes, accumulate one bit per cycle, then saturate and register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      ax    <= '0;
      ay    <= '0;
      acc_x <= '0;
      acc_y <= '0;
      cnt   <= '0;
      r_out <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // -2^(W-1) maps to the unsigned pattern 2^(W-1), which still fits in W bits.
          ax    <= gx[W-1] ? W'(-gx) : W'(gx);
          ay    <= gy[W-1] ? W'(-gy) : W'(gy);
          acc_x <= '0;
          acc_y <= '0;
          cnt   <= '0;
        end
        MUL: begin
          acc_x <= acc_x + px;
          acc_y <= acc_y + py;
          cnt   <= cnt + CW'(1);
        end
        SAT: begin
          if (|s[SW-1:16]) begin
            r_out <= 16'hFFFF;
            sat   <= 1'b1;
          end else begin
            r_out <= s[15:0];
            sat   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_mag_sq_seq.sv
// Directed bench for sobel_mag_sq_seq. It drives a default instance and a SCALE_SHIFT=0 instance.
module tb_sobel_mag_sq_seq;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] gx = '0, gy = '0, gx0 = '0, gy0 = '0;
  logic in_valid = 1'b0, in_valid0 = 1'b0;
  logic out_ready = 1'b1, out_ready0 = 1'b1;
  logic in_ready, in_ready0, sat, sat0, out_valid, out_valid0;
  logic [15:0] r_out, r_out0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sobel_mag_sq_seq #(.W(W), .SCALE_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .gx(gx), .gy(gy), .in_valid(in_valid), .in_ready(in_ready),
    .r_out(r_out), .sat(sat), .out_valid(out_valid), .out_ready(out_ready));

  sobel_mag_sq_seq #(.W(W), .SCALE_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .gx(gx0), .gy(gy0), .in_valid(in_valid0), .in_ready(in_ready0),
    .r_out(r_out0), .sat(sat0), .out_valid(out_valid0), .out_ready(out_ready0));

  // Stimulus only: accept one sample and report latency, result and in_ready activity.
  // Returns lat = -1 if the sample is never accepted, or 99 if no result appears.
  task automatic issue(input bit sel, input int x, input int y,
                       output int lat, output int r, output bit s, output bit rdy_seen);
    int k = 0;
    rdy_seen = 1'b0;
    while (!(sel ? in_ready0 : in_ready) && k < 50) begin
      @(negedge clk); k++;
    end
    if (k == 50) begin
      lat = -1; r = -1; s = 1'b0;
      return;
    end
    if (sel) begin gx0 = W'(x); gy0 = W'(y); in_valid0 = 1'b1; end
    else     begin gx  = W'(x); gy  = W'(y); in_valid  = 1'b1; end
    @(negedge clk);
    in_valid = 1'b0; in_valid0 = 1'b0;
    lat = 0;
    while (!(sel ? out_valid0 : out_valid) && lat < 99) begin
      rdy_seen |= (sel ? in_ready0 : in_ready);
      @(negedge clk); lat++;
    end
    r = sel ? int'(r_out0) : int'(r_out);
    s = sel ? sat0 : sat;
  endtask

  task automatic test_reset();
    bit bad_hold = 1'b0;
    bit ov_seen = 1'b0;
    rst = 1'b1; in_valid = 1'b1; gx = 11'sd100; gy = 11'sd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || r_out !== 16'd0 || sat !== 1'b0 || in_ready !== 1'b0) begin
        $display("FAIL reset_hold c=%0d: ov=%b r=%0d sat=%b ir=%b, want 0/0/0/0",
                 c, out_valid, r_out, sat, in_ready);
        bad_hold = 1'b1;
      end else passed++;
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    else passed++;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ov_seen |= (out_valid === 1'b1);
    end
    total++;
    if (ov_seen) $display("FAIL reset_ignored_sample: out_valid seen=1, want 0");
    else passed++;
    if (bad_hold) ;
  endtask

  task automatic test_nominal();
    int lat, r; bit s, rs;
    out_ready = 1'b1;
    issue(1'b0, 300, -400, lat, r, s, rs);
    total++;
    if (lat !== 12) $display("FAIL nominal_latency: got %0d, want 12", lat); else passed++;
    total++;
    if (r !== 7812 || s !== 1'b0) $display("FAIL nominal_value: r=%0d sat=%b, want 7812/0", r, s);
    else passed++;
    total++;
    if (rs !== 1'b0) $display("FAIL nominal_in_ready_busy: seen=%b, want 0", rs); else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL nominal_return: ov=%b ir=%b, want 0/1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_values();
    int lat, r; bit s, rs;
    int vx [5] = '{1020, 0, -1024, 1023, 1023};
    int vy [5] = '{-1020, 0, -1024, 1023, -1024};
    int er [5] = '{65025, 0, 65535, 65408, 65472};
    bit es [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      issue(1'b0, vx[t], vy[t], lat, r, s, rs);
      total++;
      if (lat !== 12 || r !== er[t] || s !== es[t])
        $display("FAIL value_%0d (gx=%0d gy=%0d): lat=%0d r=%0d sat=%b, want 12/%0d/%b",
                 t, vx[t], vy[t], lat, r, s, er[t], es[t]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int c = 0;
    int accepts = 0;
    int first = -1;
    int second = -1;
    // Hold in_valid and out_ready high, then measure the gap between accept edges.
    out_ready = 1'b1; gx = 11'sd5; gy = 11'sd7; in_valid = 1'b1;
    while (accepts < 2 && c < 60) begin
      if (in_ready) begin
        if (accepts == 0) first = c; else second = c;
        accepts++;
      end
      @(negedge clk); c++;
    end
    in_valid = 1'b0;
    total++;
    if (second - first !== 14)
      $display("FAIL back_to_back_interval: got %0d, want 14", second - first);
    else passed++;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat, r; bit s, rs;
    bit bad = 1'b0;
    out_ready0 = 1'b0;
    issue(1'b1, 3, 4, lat, r, s, rs);
    total++;
    if (lat !== 12 || r !== 25 || s !== 1'b0)
      $display("FAIL bp_value: lat=%0d r=%0d sat=%b, want 12/25/0", lat, r, s);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid0 !== 1'b1 || r_out0 !== 16'd25 || in_ready0 !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL bp_hold: ov=%b r=%0d ir=%b, want 1/25/0", out_valid0, r_out0, in_ready0);
    else passed++;
    out_ready0 = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1)
      $display("FAIL bp_release: ov=%b ir=%b, want 0/1", out_valid0, in_ready0);
    else passed++;
  endtask

  task automatic test_reset_mid_mul();
    int lat, r; bit s, rs;
    bit ov_seen = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    gx = 11'sd500; gy = 11'sd500; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      ov_seen |= (out_valid === 1'b1);
      @(negedge clk);
    end
    total++;
    if (ov_seen) $display("FAIL midreset_discard: out_valid seen=1, want 0"); else passed++;
    issue(1'b0, 8, 8, lat, r, s, rs);
    total++;
    if (lat !== 12 || r !== 4 || s !== 1'b0)
      $display("FAIL midreset_next: lat=%0d r=%0d sat=%b, want 12/4/0", lat, r, s);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case a bounded loop is ever missed
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
